sdram_controller_model: RTL and testbench

- Cycle-level synthesizable responder for the SDRAM controller user interface (I_sdrc_*/O_sdrc_*), standing in for the vendor controller in simulation and BRAM-backed FPGA builds.
- Accepts the same command/address/burst signals that ramio drives, and answers with init_done, cmd_ack and read data.
- Backs the data with an internal word array and checks protocol use.

---
 rtl/sdram_controller_model.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_sdram_controller_model.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_controller_model.sv
// sdram_controller_model
//   Cycle-level stand-in for the vendor SDRAM controller user interface.
//   Accepts one command at a time, acknowledges it, and services write
//   and read bursts from an internal word array. Misuse of the interface
//   raises a sticky protocol_error flag.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   I_sdrc_cmd_en            command strobe (accepted only when idle)
//   I_sdrc_cmd[2:0]          MRS/refresh/precharge/activate/write/read/NOP
//   I_sdrc_addr[20:0]        {bank[1:0], row[10:0], col[7:0]}
//   I_sdrc_data[31:0]        write data, one beat per cycle
//   I_sdrc_dqm[3:0]          per-byte write mask (1 = keep old byte)
//   I_sdrc_data_len[7:0]     burst beats minus one
//   I_sdrc_precharge_ctrl, I_sdram_power_down, I_sdram_selfrefresh
//                            accepted for compatibility, no effect
//   O_sdrc_data[31:0]        read data
//   O_sdrc_init_done         controller ready
//   O_sdrc_cmd_ack           one-cycle command acknowledge
//   protocol_error           sticky misuse flag
module sdram_controller_model #(
  parameter int MemAddressBitWidth = 12,
  parameter int InitCycles         = 16,
  parameter int CasLatency         = 2,
  parameter int AckDelay           = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        I_sdrc_cmd_en,
  input  logic [2:0]  I_sdrc_cmd,
  input  logic [20:0] I_sdrc_addr,
  input  logic [31:0] I_sdrc_data,
  input  logic [3:0]  I_sdrc_dqm,
  input  logic [7:0]  I_sdrc_data_len,
  input  logic        I_sdrc_precharge_ctrl,
  input  logic        I_sdram_power_down,
  input  logic        I_sdram_selfrefresh,
  output logic [31:0] O_sdrc_data,
  output logic        O_sdrc_init_done,
  output logic        O_sdrc_cmd_ack,
  output logic        protocol_error
);

  localparam int AW = MemAddressBitWidth;

  localparam logic [2:0] CMD_MRS       = 3'b000;
  localparam logic [2:0] CMD_REFRESH   = 3'b001;
  localparam logic [2:0] CMD_PRECHARGE = 3'b010;
  localparam logic [2:0] CMD_ACTIVATE  = 3'b011;
  localparam logic [2:0] CMD_WRITE     = 3'b100;
  localparam logic [2:0] CMD_READ      = 3'b101;
  localparam logic [2:0] CMD_NOP       = 3'b111;

  localparam logic [15:0] INIT_LAST = 16'(InitCycles - 1);
  localparam logic [2:0]  ACK_START = 3'(AckDelay - 1);
  // READ_LAT is only entered when CasLatency > 1; it lasts CasLatency-1 cycles
  localparam logic [2:0]  LAT_START = 3'((CasLatency > 1) ? (CasLatency - 2) : 0);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ACK_WAIT,
    ST_WRITE_BURST,
    ST_READ_LAT,
    ST_READ_BURST
  } state_t;

  // Word index: {bank,row,col} truncated to the stored address width
  function automatic logic [AW-1:0] mem_index(input logic [1:0] bank,
                                              input logic [10:0] row,
                                              input logic [7:0] col);
    return AW'({bank, row, col});
  endfunction

  state_t      r_state;
  logic [15:0] r_init_cnt;
  logic        r_init_done;
  logic        r_ack;
  logic [31:0] r_data;
  logic        r_err;
  logic [3:0]  r_bank_open;
  logic [2:0]  r_cmd;
  logic [20:0] r_addr;
  logic [7:0]  r_len;
  logic [7:0]  r_beat;
  logic [2:0]  r_ack_cnt;
  logic [2:0]  r_lat_cnt;
  logic        r_wr_active;
  logic        r_bank_ok;
  logic [31:0] r_mem [0:(1<<AW)-1];

  logic [1:0]    w_in_bank;
  logic          w_in_bank_open;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_idx;
  logic [31:0]   w_mem_wdata;
  logic [3:0]    w_mem_dqm;
  logic [7:0]    w_rd_beat;
  logic [AW-1:0] w_rd_idx;
  logic [31:0]   w_rd_word;
  logic          w_unused;

  assign w_in_bank      = I_sdrc_addr[20:19];
  assign w_in_bank_open = r_bank_open[w_in_bank];
  assign w_unused       = ^{I_sdrc_precharge_ctrl, I_sdram_power_down, I_sdram_selfrefresh};

  assign O_sdrc_data      = r_data;
  assign O_sdrc_init_done = r_init_done;
  assign O_sdrc_cmd_ack   = r_ack;
  assign protocol_error   = r_err;

  // Memory write port: beat 0 at accept, later beats while the burst runs
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_idx   = {AW{1'b0}};
    w_mem_wdata = 32'd0;
    w_mem_dqm   = 4'hF;
    if ((r_state == ST_IDLE) && I_sdrc_cmd_en && (I_sdrc_cmd == CMD_WRITE) && w_in_bank_open) begin
      w_mem_we    = 1'b1;
      w_mem_idx   = mem_index(I_sdrc_addr[20:19], I_sdrc_addr[18:8], I_sdrc_addr[7:0]);
      w_mem_wdata = I_sdrc_data;
      w_mem_dqm   = I_sdrc_dqm;
    end else if (r_wr_active && r_bank_ok) begin
      w_mem_we    = 1'b1;
      w_mem_idx   = mem_index(r_addr[20:19], r_addr[18:8], r_addr[7:0] + r_beat);
      w_mem_wdata = I_sdrc_data;
      w_mem_dqm   = I_sdrc_dqm;
    end else begin
      w_mem_we    = 1'b0;
    end
  end

  // Read port: next beat to present (column wraps within the row)
  always_comb begin
    w_rd_beat = (r_state == ST_READ_BURST) ? (r_beat + 8'd1) : 8'd0;
    w_rd_idx  = mem_index(r_addr[20:19], r_addr[18:8], r_addr[7:0] + w_rd_beat);
    if (r_bank_ok) begin
      w_rd_word = r_mem[w_rd_idx];
    end else begin
      w_rd_word = 32'd0;
    end
  end

  // Backing store; deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (w_mem_we && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (!w_mem_dqm[b]) begin
          r_mem[w_mem_idx][8*b +: 8] <= w_mem_wdata[8*b +: 8];
        end
      end
    end
  end

  // Command FSM, bank tracking, burst counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_init_cnt  <= 16'd0;
      r_init_done <= 1'b0;
      r_ack       <= 1'b0;
      r_data      <= 32'd0;
      r_err       <= 1'b0;
      r_bank_open <= 4'd0;
      r_cmd       <= CMD_NOP;
      r_addr      <= 21'd0;
      r_len       <= 8'd0;
      r_beat      <= 8'd0;
      r_ack_cnt   <= 3'd0;
      r_lat_cnt   <= 3'd0;
      r_wr_active <= 1'b0;
      r_bank_ok   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      // Any strobe outside IDLE (including INIT) is misuse and is dropped
      if (I_sdrc_cmd_en && (r_state != ST_IDLE)) begin
        r_err <= 1'b1;
      end
      // Write beats 1..len are sampled from the cycle after accept,
      // independent of whether the ack has gone out yet
      if (r_wr_active) begin
        if (r_beat == r_len) begin
          r_wr_active <= 1'b0;
        end else begin
          r_beat <= r_beat + 8'd1;
        end
      end
      case (r_state)
        ST_INIT: begin
          if (r_init_cnt == INIT_LAST) begin
            r_init_done <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_init_cnt <= r_init_cnt + 16'd1;
          end
        end
        ST_IDLE: begin
          if (I_sdrc_cmd_en) begin
            r_cmd       <= I_sdrc_cmd;
            r_addr      <= I_sdrc_addr;
            r_len       <= I_sdrc_data_len;
            r_beat      <= 8'd1;
            r_wr_active <= (I_sdrc_cmd == CMD_WRITE) && (I_sdrc_data_len != 8'd0);
            r_bank_ok   <= w_in_bank_open;
            r_ack_cnt   <= ACK_START;
            r_ack       <= (AckDelay == 1);
            r_state     <= ST_ACK_WAIT;
            case (I_sdrc_cmd)
              CMD_ACTIVATE: begin
                if (w_in_bank_open) begin
                  r_err <= 1'b1;
                end
                r_bank_open[w_in_bank] <= 1'b1;
              end
              CMD_PRECHARGE: begin
                // A10 selects precharge-all
                if (I_sdrc_addr[18]) begin
                  r_bank_open <= 4'd0;
                end else begin
                  r_bank_open[w_in_bank] <= 1'b0;
                end
              end
              CMD_REFRESH: begin
                if (|r_bank_open) begin
                  r_err <= 1'b1;
                end
              end
              CMD_WRITE, CMD_READ: begin
                if (!w_in_bank_open) begin
                  r_err <= 1'b1;
                end
              end
              default: begin
                r_err <= r_err;
              end
            endcase
          end
        end
        ST_ACK_WAIT: begin
          if (r_ack) begin
            case (r_cmd)
              CMD_WRITE: begin
                // A short burst may already be finishing on this edge
                if (r_wr_active && (r_beat != r_len)) begin
                  r_state <= ST_WRITE_BURST;
                end else begin
                  r_state <= ST_IDLE;
                end
              end
              CMD_READ: begin
                if (CasLatency == 1) begin
                  r_data  <= w_rd_word;
                  r_beat  <= 8'd0;
                  r_state <= ST_READ_BURST;
                end else begin
                  r_lat_cnt <= LAT_START;
                  r_state   <= ST_READ_LAT;
                end
              end
              default: begin
                r_state <= ST_IDLE;
              end
            endcase
          end else begin
            r_ack_cnt <= r_ack_cnt - 3'd1;
            if (r_ack_cnt == 3'd1) begin
              r_ack <= 1'b1;
            end
          end
        end
        ST_WRITE_BURST: begin
          if (r_beat == r_len) begin
            r_state <= ST_IDLE;
          end
        end
        ST_READ_LAT: begin
          if (r_lat_cnt == 3'd0) begin
            r_data  <= w_rd_word;
            r_beat  <= 8'd0;
            r_state <= ST_READ_BURST;
          end else begin
            r_lat_cnt <= r_lat_cnt - 3'd1;
          end
        end
        ST_READ_BURST: begin
          // Last beat holds on the output after the burst ends
          if (r_beat == r_len) begin
            r_state <= ST_IDLE;
          end else begin
            r_beat <= r_beat + 8'd1;
            r_data <= w_rd_word;
          end
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_controller_model.sv
// Testbench for sdram_controller_model: directed scenarios followed by a
// randomized command stream, all checked against a transaction-level model
// (bank-open flags, sticky error flag, word array with known-value tracking).
module tb_sdram_controller_model;

  localparam int AW   = 12;
  localparam int INIT = 16;
  localparam int CL   = 2;
  localparam int AD   = 1;

  localparam logic [2:0] C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100, C_RD  = 3'b101, C_NOP = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        I_sdrc_cmd_en = 1'b0;
  logic [2:0]  I_sdrc_cmd = 3'b111;
  logic [20:0] I_sdrc_addr = 21'd0;
  logic [31:0] I_sdrc_data = 32'd0;
  logic [3:0]  I_sdrc_dqm = 4'd0;
  logic [7:0]  I_sdrc_data_len = 8'd0;
  logic        I_sdrc_precharge_ctrl = 1'b0;
  logic        I_sdram_power_down = 1'b0;
  logic        I_sdram_selfrefresh = 1'b0;
  logic [31:0] O_sdrc_data;
  logic        O_sdrc_init_done;
  logic        O_sdrc_cmd_ack;
  logic        protocol_error;

  always #5 clk = ~clk;

  sdram_controller_model #(
    .MemAddressBitWidth(AW), .InitCycles(INIT), .CasLatency(CL), .AckDelay(AD)
  ) dut (
    .clk(clk), .rst(rst),
    .I_sdrc_cmd_en(I_sdrc_cmd_en), .I_sdrc_cmd(I_sdrc_cmd), .I_sdrc_addr(I_sdrc_addr),
    .I_sdrc_data(I_sdrc_data), .I_sdrc_dqm(I_sdrc_dqm), .I_sdrc_data_len(I_sdrc_data_len),
    .I_sdrc_precharge_ctrl(I_sdrc_precharge_ctrl), .I_sdram_power_down(I_sdram_power_down),
    .I_sdram_selfrefresh(I_sdram_selfrefresh),
    .O_sdrc_data(O_sdrc_data), .O_sdrc_init_done(O_sdrc_init_done),
    .O_sdrc_cmd_ack(O_sdrc_cmd_ack), .protocol_error(protocol_error)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] ref_mem   [0:(1<<AW)-1];
  bit          ref_known [0:(1<<AW)-1];
  bit          ref_open  [0:3];
  bit          ref_err;
  logic [31:0] wdata [0:255];
  logic [3:0]  wdqm  [0:255];
  logic [31:0] last_rd;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int widx(input int bank, input int row, input int col);
    return ((bank * (1 << 19)) + ((row % 2048) * 256) + (col % 256)) % (1 << AW);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    int cnt;
    rst = 1'b1;
    I_sdrc_cmd_en = 1'b0;
    #1;
    check_eq("rst_data", O_sdrc_data, 32'd0);
    check_eq("rst_init_done", {31'd0, O_sdrc_init_done}, 32'd0);
    check_eq("rst_ack", {31'd0, O_sdrc_cmd_ack}, 32'd0);
    check_eq("rst_perr", {31'd0, protocol_error}, 32'd0);
    repeat (3) step();
    rst = 1'b0;
    cnt = 0;
    while (!O_sdrc_init_done && cnt < 100) begin
      if (O_sdrc_cmd_ack) check_eq("init_ack", {31'd0, O_sdrc_cmd_ack}, 32'd0);
      step();
      cnt++;
    end
    check_eq("init_cycles", cnt, INIT);
    for (int b = 0; b < 4; b++) ref_open[b] = 1'b0;
    ref_err = 1'b0;
  endtask

  // Issue one command and follow it to completion. poke_at: cycle in which a
  // stray cmd_en is pulsed (0 = none). rst_at: cycle in which reset hits (0 = none).
  task automatic do_cmd(input logic [2:0] cmd, input int bank, input int row, input int col,
                        input int len, input int poke_at, input int rst_at);
    bit          open_acc;
    logic [31:0] exp_rd [0:255];
    bit          exp_kn [0:255];
    int          end_t, k, idx;
    logic [1:0]  a_bank;
    logic [10:0] a_row;
    logic [7:0]  a_col;
    a_bank = bank[1:0];
    a_row  = row[10:0];
    a_col  = col[7:0];
    open_acc = ref_open[bank];
    case (cmd)
      C_ACT: begin
        if (ref_open[bank]) ref_err = 1'b1;
        ref_open[bank] = 1'b1;
      end
      C_PRE: begin
        if (a_row[10]) for (int b = 0; b < 4; b++) ref_open[b] = 1'b0;
        else ref_open[bank] = 1'b0;
      end
      C_REF: if (ref_open[0] || ref_open[1] || ref_open[2] || ref_open[3]) ref_err = 1'b1;
      C_WR, C_RD: if (!open_acc) ref_err = 1'b1;
      default: ;
    endcase
    for (int j = 0; j <= len; j++) begin
      idx = widx(bank, row, col + j);
      exp_rd[j] = open_acc ? ref_mem[idx] : 32'd0;
      exp_kn[j] = open_acc ? ref_known[idx] : 1'b1;
    end
    if (cmd == C_RD) end_t = AD + CL + len + 1;
    else if (cmd == C_WR) end_t = ((AD > len) ? AD : len) + 1;
    else end_t = AD + 1;

    I_sdrc_cmd_en   = 1'b1;
    I_sdrc_cmd      = cmd;
    I_sdrc_addr     = {a_bank, a_row, a_col};
    I_sdrc_data_len = len[7:0];
    I_sdrc_data     = wdata[0];
    I_sdrc_dqm      = wdqm[0];
    step();
    if (cmd == C_WR && open_acc) commit(bank, row, col, 0);
    for (int t = 1; t <= end_t; t++) begin
      if (t == rst_at) begin
        do_reset();
        return;
      end
      if (cmd == C_WR && t <= len) begin
        I_sdrc_data = wdata[t];
        I_sdrc_dqm  = wdqm[t];
      end
      if (t == poke_at) begin
        I_sdrc_cmd_en = 1'b1;
        I_sdrc_cmd    = C_NOP;
        ref_err       = 1'b1;
      end else begin
        I_sdrc_cmd_en = 1'b0;
      end
      check_eq("ack", {31'd0, O_sdrc_cmd_ack}, (t == AD) ? 32'd1 : 32'd0);
      if (cmd == C_RD) begin
        k = t - (AD + CL);
        if (k >= 0 && k <= len) begin
          if (exp_kn[k]) check_eq("rd_beat", O_sdrc_data, exp_rd[k]);
          if (k == len) last_rd = O_sdrc_data;
        end
        if (t == end_t && exp_kn[len]) check_eq("rd_hold", O_sdrc_data, exp_rd[len]);
      end
      if (t < end_t) begin
        step();
        if (cmd == C_WR && t <= len && open_acc) commit(bank, row, col, t);
      end
    end
    I_sdrc_cmd_en = 1'b0;
    check_eq("perr", {31'd0, protocol_error}, {31'd0, ref_err});
  endtask

  task automatic commit(input int bank, input int row, input int col, input int k);
    int idx;
    idx = widx(bank, row, col + k);
    for (int b = 0; b < 4; b++)
      if (!wdqm[k][b]) ref_mem[idx][8*b +: 8] = wdata[k][8*b +: 8];
    ref_known[idx] = ref_known[idx] || (wdqm[k] == 4'd0);
  endtask

  task automatic fill_random(input int len);
    for (int j = 0; j <= len; j++) begin
      wdata[j] = $urandom;
      wdqm[j]  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c, bank, row, col, len;
    for (int i = 0; i < (1 << AW); i++) begin
      ref_mem[i] = 32'd0;
      ref_known[i] = 1'b0;
    end
    for (int j = 0; j < 256; j++) begin
      wdata[j] = 32'd0;
      wdqm[j] = 4'd0;
    end
    last_rd = 32'd0;

    // Reset and initialisation
    do_reset();

    // Burst write/read with column wrap 254,255,0,1
    do_cmd(C_ACT, 1, 5, 0, 0, 0, 0);
    for (int j = 0; j < 4; j++) wdata[j] = 32'hA0 + j;
    do_cmd(C_WR, 1, 5, 254, 3, 0, 0);
    do_cmd(C_RD, 1, 5, 254, 3, 0, 0);
    check_eq("wrap_last", last_rd, 32'h0000_00A3);

    // Byte masking
    wdata[0] = 32'hFFFF_FFFF; wdqm[0] = 4'b0000;
    do_cmd(C_WR, 1, 5, 20, 0, 0, 0);
    wdata[0] = 32'h1234_5678; wdqm[0] = 4'b0101;
    do_cmd(C_WR, 1, 5, 20, 0, 0, 0);
    wdqm[0] = 4'b0000;
    do_cmd(C_RD, 1, 5, 20, 0, 0, 0);
    check_eq("dqm_merge", last_rd, 32'h12FF_56FF);

    // Closed-bank access, precharge-all, discarded write
    do_cmd(C_RD, 2, 7, 0, 3, 0, 0);
    check_eq("closed_rd", last_rd, 32'd0);
    do_cmd(C_PRE, 1, 1024, 0, 0, 0, 0);
    wdata[0] = 32'hDEAD_0000; wdata[1] = 32'hDEAD_0001;
    do_cmd(C_WR, 1, 5, 254, 1, 0, 0);
    do_cmd(C_ACT, 1, 5, 0, 0, 0, 0);
    do_cmd(C_RD, 1, 5, 254, 1, 0, 0);
    check_eq("discarded_wr", last_rd, 32'h0000_00A1);

    // Stray cmd_en during a read burst
    do_reset();
    do_cmd(C_ACT, 1, 5, 0, 0, 0, 0);
    do_cmd(C_RD, 1, 5, 254, 3, AD + CL + 1, 0);
    check_eq("poke_last", last_rd, 32'h0000_00A3);

    // Reset in the middle of a len=7 write
    do_reset();
    do_cmd(C_ACT, 1, 5, 0, 0, 0, 0);
    for (int j = 0; j < 8; j++) begin wdata[j] = 32'h5000_0000 + j; wdqm[j] = 4'd0; end
    do_cmd(C_WR, 1, 5, 10, 7, 0, 0);
    for (int j = 0; j < 8; j++) wdata[j] = 32'h6000_0000 + j;
    do_cmd(C_WR, 1, 5, 10, 7, 0, 4);
    do_cmd(C_ACT, 1, 5, 0, 0, 0, 0);
    do_cmd(C_RD, 1, 5, 10, 7, 0, 0);
    check_eq("rst_mid_last", last_rd, 32'h5000_0007);

    // Randomized command stream
    do_reset();
    for (int i = 0; i < 150; i++) begin
      c    = $urandom_range(0, 9);
      bank = $urandom_range(0, 3);
      row  = $urandom_range(0, 3);
      col  = $urandom_range(0, 255);
      len  = $urandom_range(0, 12);
      if ((c >= 5) && !ref_open[bank] && ($urandom_range(0, 3) != 0))
        do_cmd(C_ACT, bank, row, 0, 0, 0, 0);
      case (c)
        0: do_cmd(C_ACT, bank, row, 0, 0, 0, 0);
        1: do_cmd(C_PRE, bank, row + 1024 * $urandom_range(0, 1), 0, 0, 0, 0);
        2: do_cmd(C_REF, bank, row, 0, 0, 0, 0);
        3: do_cmd(C_MRS, bank, row, col, 0, 0, 0);
        4: do_cmd(C_NOP, bank, row, col, 0, 0, 0);
        5, 6: begin
          fill_random(len);
          do_cmd(C_WR, bank, row, col, len, 0, 0);
        end
        default: do_cmd(C_RD, bank, row, col, len, 0, 0);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
